// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked ripple-carry add/sub, one chunk per stage, valid/ready with flush
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] v, adv, c;
    logic [TAG_W-1:0]  tg [STAGES];
    logic [WIDTH-1:0]  sm [STAGES];
    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  bx;
    logic              msb_cin;

    assign bx        = in_sub ? ~in_b : in_b;
    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign out_sum   = sm[STAGES-1];
    assign out_cout  = c[STAGES-1];
    assign out_ovf   = msb_cin ^ c[STAGES-1];
    assign out_zero  = out_valid & ~|out_sum;
    assign out_tag   = tg[STAGES-1];

    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            logic             pv, pc;
            logic [TAG_W-1:0] pt;
            logic [WIDTH-1:0] pa, pb, ps;
            logic [CW:0]      ch;
            logic             v_q, c_q;
            logic [TAG_W-1:0] t_q;
            logic [WIDTH-1:0] s_q, a_q, b_q;
            if (s == 0) begin : g_in
                assign pv = in_valid & adv[0];
                assign pc = in_sub;
                assign pt = in_tag;
                assign pa = in_a;
                assign pb = bx;
                assign ps = '0;
            end else begin : g_mid
                assign pv = v[s-1];
                assign pc = c[s-1];
                assign pt = tg[s-1];
                assign pa = ra[s-1];
                assign pb = rb[s-1];
                assign ps = sm[s-1];
            end
            // a stage may load whenever no full run of valid stages from here to the output is blocked
            assign adv[s] = out_ready | ~&v[STAGES-1:s];
            assign ch     = {1'b0, pa[CW-1:0]} + {1'b0, pb[CW-1:0]} + {{CW{1'b0}}, pc};
            // add this stage's chunk, shift the remaining operand chunks down, hold when stalled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    t_q <= '0;
                    s_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    if (adv[s]) begin
                        c_q <= ch[CW];
                        t_q <= pt;
                        s_q <= ps | (WIDTH'(ch[CW-1:0]) << (s * CW));
                        a_q <= pa >> CW;
                        b_q <= pb >> CW;
                    end
                    v_q <= !flush & (adv[s] ? pv : v_q);
                end
            end
            if (s == STAGES - 1) begin : g_last
                // carry into the MSB recovered from the sum bit, kept for signed overflow
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        msb_cin <= 1'b0;
                    else if (adv[s])
                        msb_cin <= ch[CW-1] ^ pa[CW-1] ^ pb[CW-1];
                end
            end
            assign v[s]  = v_q;
            assign c[s]  = c_q;
            assign tg[s] = t_q;
            assign sm[s] = s_q;
            assign ra[s] = a_q;
            assign rb[s] = b_q;
        end
    endgenerate
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table vectors and scoreboard checks for pipelined_adder
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 4;
    localparam int T = 6;

    logic         clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_sub = 0, out_ready = 1;
    logic         in_ready, out_valid, out_cout, out_ovf, out_zero;
    logic [W-1:0] in_a = '0, in_b = '0, out_sum;
    logic [T-1:0] in_tag = '0, out_tag;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic [T-1:0] tag;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    res_t q[$];
    res_t exp_cur;
    int   n_vec = 0, n_bad = 0;
    vec_t tbl[10];

    pipelined_adder #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic [T-1:0] tag);
        logic [W-1:0] bb;
        logic [W:0]   r;
        res_t         m;
        bb     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        m.sum  = r[W-1:0];
        m.cout = r[W];
        m.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        m.zero = (r[W-1:0] == '0);
        m.tag  = tag;
        return m;
    endfunction

    function automatic res_t actual();
        res_t m;
        m = {out_sum, out_cout, out_ovf, out_zero, out_tag};
        return m;
    endfunction

    // scoreboard: compare at the output handshake, push at the input handshake
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0)
                    check("out_valid_idle", 64'(out_valid), 64'(0));
                else if (out_ready) begin
                    e = q.pop_front();
                    check("result", 64'(actual()), 64'(e));
                end else
                    check("stall_hold", 64'(actual()), 64'(q[0]));
            end
            if (flush)
                q.delete();
            else if (in_valid && in_ready)
                q.push_back(exp_cur);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input res_t e, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic acc;
        exp_cur  = e;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_tag   = e.tag;
        in_valid = 1;
        acc      = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            step();
        end
        in_valid = 0;
        if (!acc) check("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic send_rand(input logic [T-1:0] tag);
        logic [W-1:0] a, b;
        logic         sub;
        a   = $urandom;
        b   = $urandom;
        sub = tag[0];
        send(model(a, b, sub, tag), a, b, sub);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) step();
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic send_vec(input int i);
        res_t e;
        e.sum  = tbl[i].sum;
        e.cout = tbl[i].cout;
        e.ovf  = tbl[i].ovf;
        e.zero = tbl[i].zero;
        e.tag  = T'(10 + i);
        send(e, tbl[i].a, tbl[i].b, tbl[i].sub);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nxt;
        logic [W-1:0] a, b;
        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

        #2;
        check("reset_state", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag, in_ready}), 64'h1);
        step();
        step();
        rst_n = 1;
        step();

        send_vec(0);
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("latency", 64'(n), 64'(4));
        drain();
        for (int i = 1; i < 10; i++) send_vec(i);
        drain();

        nxt = 0;
        for (int k = 0; k < 13; k++) begin
            logic acc;
            out_ready = !(k >= 5 && k <= 9);
            if (nxt < 8) begin
                a        = $urandom;
                b        = $urandom;
                in_a     = a;
                in_b     = b;
                in_sub   = nxt[0];
                in_tag   = T'(nxt);
                exp_cur  = model(a, b, nxt[0], T'(nxt));
                in_valid = 1;
            end else
                in_valid = 0;
            #1;
            check("bp_in_ready", 64'(in_ready), 64'(!(k >= 5 && k <= 9)));
            acc = in_valid && in_ready;
            step();
            if (acc) nxt++;
        end
        in_valid  = 0;
        out_ready = 1;
        check("bp_accepted", 64'(nxt), 64'(8));
        drain();

        for (int j = 0; j < 3; j++) send_rand(T'(20 + j));
        a        = $urandom;
        in_a     = a;
        in_tag   = T'(23);
        exp_cur  = model(a, in_b, in_sub, T'(23));
        in_valid = 1;
        flush    = 1;
        step();
        flush    = 0;
        in_valid = 0;
        send_rand(T'(24));
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("flush_latency", 64'(n), 64'(4));
        drain();

        out_ready = 0;
        for (int j = 0; j < 4; j++) send_rand(T'(30 + j));
        check("full_in_ready", 64'({out_valid, in_ready}), 64'b10);
        #2;
        rst_n = 0;
        #1;
        check("async_rst", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag, in_ready}), 64'h1);
        step();
        step();
        rst_n     = 1;
        out_ready = 1;
        #1;
        check("post_rst", 64'({out_valid, in_ready}), 64'b01);
        send_rand(T'(40));
        send_rand(T'(41));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
